// File: rtl/rect_sbox_share_compress.sv
// Three-share compression of RECT S-box nonlinear terms with ring refresh.
// S1 registers raw terms as a glitch barrier; S2 registers refreshed shares.
module rect_sbox_share_compress #(
    parameter int NCOORD = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [27*NCOORD-1:0]  term_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*NCOORD-1:0]   rnd,
    input  logic                  rnd_valid,
    output logic [NCOORD-1:0]     share1_out,
    output logic [NCOORD-1:0]     share2_out,
    output logic [NCOORD-1:0]     share3_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      eval_cnt
);

    logic [27*NCOORD-1:0] s1_terms_q, s1_terms_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [NCOORD-1:0]    share1_q, share1_d;
    logic [NCOORD-1:0]    share2_q, share2_d;
    logic [NCOORD-1:0]    share3_q, share3_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     eval_cnt_q, eval_cnt_d;

    logic                 s1_adv;
    logic                 in_xfer;
    logic                 out_xfer;
    logic [NCOORD-1:0]    c1, c2, c3;

    always_comb begin
        s1_adv   = s1_valid_q & rnd_valid & (~out_valid_q | out_ready);
        in_ready = ~s1_valid_q | s1_adv;
        in_xfer  = in_valid & in_ready;
        out_xfer = out_valid_q & out_ready;
    end

    // Each share draws on a disjoint third of the terms, so no register mixes shares.
    always_comb begin
        c1 = '0;
        c2 = '0;
        c3 = '0;
        for (int unsigned k = 0; k < NCOORD; k++) begin
            c1[k] = ^s1_terms_q[27*k      +: 9];
            c2[k] = ^s1_terms_q[27*k + 9  +: 9];
            c3[k] = ^s1_terms_q[27*k + 18 +: 9];
        end
    end

    always_comb begin
        s1_terms_d  = s1_terms_q;
        s1_valid_d  = s1_valid_q;
        share1_d    = share1_q;
        share2_d    = share2_q;
        share3_d    = share3_q;
        out_valid_d = out_valid_q;
        eval_cnt_d  = eval_cnt_q;

        if (in_xfer) begin
            s1_terms_d = term_in;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            for (int unsigned k = 0; k < NCOORD; k++) begin
                share1_d[k] = c1[k] ^ rnd[3*k]     ^ rnd[3*k + 1];
                share2_d[k] = c2[k] ^ rnd[3*k + 1] ^ rnd[3*k + 2];
                share3_d[k] = c3[k] ^ rnd[3*k + 2] ^ rnd[3*k];
            end
            out_valid_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (out_xfer && (eval_cnt_q != '1)) begin
            eval_cnt_d = eval_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_terms_q  <= '0;
            s1_valid_q  <= 1'b0;
            share1_q    <= '0;
            share2_q    <= '0;
            share3_q    <= '0;
            out_valid_q <= 1'b0;
            eval_cnt_q  <= '0;
        end else begin
            s1_terms_q  <= s1_terms_d;
            s1_valid_q  <= s1_valid_d;
            share1_q    <= share1_d;
            share2_q    <= share2_d;
            share3_q    <= share3_d;
            out_valid_q <= out_valid_d;
            eval_cnt_q  <= eval_cnt_d;
        end
    end

    assign share1_out = share1_q;
    assign share2_out = share2_q;
    assign share3_out = share3_q;
    assign out_valid  = out_valid_q;
    assign eval_cnt   = eval_cnt_q;

endmodule

// File: tb/tb_rect_sbox_share_compress.sv
// Scoreboard bench: a transaction-level model predicts shares on every S1 advance,
// a negedge monitor compares DUT outputs against the queued predictions.
module tb_rect_sbox_share_compress;

    localparam int NC = 4;
    localparam int TW = 27 * NC;
    localparam int RW = 3 * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] term_in;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] rnd;
    logic          rnd_valid;
    logic [NC-1:0] share1_out, share2_out, share3_out;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   eval_cnt;

    logic          in_ready_b, out_valid_b;
    logic [NC-1:0] sh1_b, sh2_b, sh3_b;
    logic [3:0]    eval_cnt_b;

    always #5 clk = ~clk;

    rect_sbox_share_compress #(.NCOORD(NC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .term_in(term_in), .in_valid(in_valid),
        .in_ready(in_ready), .rnd(rnd), .rnd_valid(rnd_valid),
        .share1_out(share1_out), .share2_out(share2_out), .share3_out(share3_out),
        .out_valid(out_valid), .out_ready(out_ready), .eval_cnt(eval_cnt)
    );

    rect_sbox_share_compress #(.NCOORD(NC), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .term_in(term_in), .in_valid(in_valid),
        .in_ready(in_ready_b), .rnd(rnd), .rnd_valid(rnd_valid),
        .share1_out(sh1_b), .share2_out(sh2_b), .share3_out(sh3_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .eval_cnt(eval_cnt_b)
    );

    typedef struct packed {
        logic [NC-1:0] s1;
        logic [NC-1:0] s2;
        logic [NC-1:0] s3;
        logic [NC-1:0] par;
    } shares_t;

    shares_t       exp_q[$];
    shares_t       m_last;
    bit            m_s1_full;
    bit            m_out_full;
    logic [TW-1:0] m_terms;
    int            m_cnt;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: XOR each third of a coordinate's terms, then apply the ring refresh.
    function automatic shares_t model_shares(input logic [TW-1:0] t, input logic [RW-1:0] r);
        shares_t s;
        logic    a, b, c;
        s = '0;
        for (int k = 0; k < NC; k++) begin
            a = 1'b0; b = 1'b0; c = 1'b0;
            for (int i = 0; i < 9; i++) begin
                a ^= t[27*k + i];
                b ^= t[27*k + 9 + i];
                c ^= t[27*k + 18 + i];
            end
            s.s1[k]  = a ^ r[3*k] ^ r[3*k+1];
            s.s2[k]  = b ^ r[3*k+1] ^ r[3*k+2];
            s.s3[k]  = c ^ r[3*k+2] ^ r[3*k];
            s.par[k] = ^t[27*k +: 27];
        end
        return s;
    endfunction

    // Transaction model, updated on each rising edge from the inputs the bench drove.
    initial begin
        bit      adv, oxfer, irdy;
        shares_t sh;
        m_s1_full = 0; m_out_full = 0; m_terms = '0; m_cnt = 0; m_last = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1_full = 0; m_out_full = 0; m_terms = '0; m_cnt = 0; m_last = '0;
                exp_q.delete();
            end else begin
                oxfer = m_out_full && out_ready;
                adv   = m_s1_full && rnd_valid && (!m_out_full || out_ready);
                irdy  = !m_s1_full || adv;
                if (oxfer) m_cnt++;
                if (adv) begin
                    sh = model_shares(m_terms, rnd);
                    exp_q.push_back(sh);
                    m_last = sh;
                    m_out_full = 1;
                end else if (oxfer) begin
                    m_out_full = 0;
                end
                if (in_valid && irdy) begin
                    m_terms = term_in;
                    m_s1_full = 1;
                end else if (adv) begin
                    m_s1_full = 0;
                end
            end
        end
    end

    // Monitor: compares on falling edges, pops the scoreboard on each output transfer.
    initial begin
        shares_t exp_sh;
        bit      exp_rdy;
        forever begin
            @(negedge clk);
            exp_rdy = !m_s1_full || (rnd_valid && (!m_out_full || out_ready));
            check("out_valid", out_valid, m_out_full);
            check("in_ready", in_ready, exp_rdy);
            check("eval_cnt", eval_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
            check("eval_cnt_w4", eval_cnt_b, (m_cnt > 15) ? 15 : m_cnt);
            exp_sh = (m_out_full && exp_q.size() > 0) ? exp_q[0] : m_last;
            check("share1", share1_out, exp_sh.s1);
            check("share2", share2_out, exp_sh.s2);
            check("share3", share3_out, exp_sh.s3);
            if (out_valid && m_out_full)
                check("share_xor", share1_out ^ share2_out ^ share3_out, exp_sh.par);
            if (m_out_full && out_ready && !rst && exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
    end

    task automatic rand_terms();
        for (int i = 0; i < TW; i++) term_in[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_rnd();
        for (int i = 0; i < RW; i++) rnd[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3*NC-1:0] held;
        rst = 1'b1; in_valid = 1'b0; term_in = '0; rnd = '0; rnd_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_shares", {share1_out, share2_out, share3_out}, 0);
        check("rst_cnt", eval_cnt, 0);

        // single term 0 set, no randomness
        term_in = '0; term_in[0] = 1'b1; rnd = '0;
        rnd_valid = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step();
        check("d1_valid", out_valid, 1);
        check("d1_share1", share1_out, 4'h1);
        check("d1_share2", share2_out, 4'h0);
        check("d1_share3", share3_out, 4'h0);

        // same terms, r1 of coordinate 0 set
        rnd = 12'h001; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step();
        check("d2_share1", share1_out, 4'h0);
        check("d2_share2", share2_out, 4'h0);
        check("d2_share3", share3_out, 4'h1);
        check("d2_xor", share1_out ^ share2_out ^ share3_out, 4'h1);

        // back-to-back stream
        rst = 1'b1; step(); rst = 1'b0;
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rand_terms(); rand_rnd();
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("stream_cnt", eval_cnt, 1000);
        check("stream_cnt_w4", eval_cnt_b, 4'hF);

        // output backpressure with full pipeline
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_terms(); rand_rnd(); step(); end
        held = {share1_out, share2_out, share3_out};
        for (int i = 0; i < 5; i++) begin rand_terms(); rand_rnd(); step(); end
        check("bp_stable", {share1_out, share2_out, share3_out}, held);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (4) step();

        // randomness starvation with S1 full
        rnd_valid = 1'b0; in_valid = 1'b1; rand_terms();
        step(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_rnd(); step(); end
        check("rv_stall", out_valid, 0);
        rnd_valid = 1'b1; rand_rnd();
        step();
        check("rv_resume", out_valid, 1);
        repeat (2) step();

        // random handshakes with a reset pulse mid-stream
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rnd_valid = ($urandom_range(0, 4) != 0);
            rand_terms(); rand_rnd();
            rst = (i == 200);
            step();
            if (i == 200) begin
                check("mid_rst_valid", out_valid, 0);
                check("mid_rst_cnt", eval_cnt, 0);
            end
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rnd_valid = 1'b1;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
